// File: rtl/ucode_sequencer.sv
// Microcoded control sequencer for the multicycle LC-2K core: walks a per-opcode
// microprogram one state per clock and emits a registered 8-bit control word.
module ucode_sequencer #(
    parameter int  UPC_W     = 5,
    parameter int  ONEHOT_IN = 0,
    localparam int OPC_IN_W  = (ONEHOT_IN != 0) ? 8 : 3
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                instr_valid_i,
    input  logic [OPC_IN_W-1:0] opcode_i,
    input  logic                eq_i,
    output logic                instr_ready_o,
    output logic [7:0]          ctrl_o,
    output logic                instr_done_o,
    output logic                busy_o,
    output logic                halted_o,
    output logic                illegal_o,
    output logic [UPC_W-1:0]    upc_o
);

    typedef enum logic [2:0] {
        NX_SEQ,
        NX_WAIT,
        NX_DISPATCH,
        NX_DONE,
        NX_BEQ,
        NX_HALT
    } nextKind_t;

    logic [UPC_W-1:0] r_upc;
    logic [7:0]       r_ctrl;
    logic             r_done;
    logic             r_halted;
    logic             r_illegal;
    logic [2:0]       r_opcode;

    nextKind_t        w_nxt;
    logic [UPC_W-1:0] w_upcNext;
    logic             w_doneEvt;
    logic             w_ready;
    logic             w_transfer;
    logic [2:0]       w_opcDec;
    logic             w_opcBad;

    function automatic logic [7:0] romCtrl(input logic [UPC_W-1:0] a);
        case (int'(a))
            0:       return 8'hC0;
            3:       return 8'h10;
            4:       return 8'h01;
            5:       return 8'h11;
            7:       return 8'h08;
            8:       return 8'h18;
            10:      return 8'h04;
            11:      return 8'h02;
            12:      return 8'h40;
            13:      return 8'h12;
            14:      return 8'h60;
            default: return 8'h00;
        endcase
    endfunction

    function automatic nextKind_t romNext(input logic [UPC_W-1:0] a);
        case (int'(a))
            0:                   return NX_WAIT;
            1:                   return NX_DISPATCH;
            2, 4, 6, 7, 9, 13:   return NX_SEQ;
            11:                  return NX_BEQ;
            15:                  return NX_HALT;
            default:             return NX_DONE;
        endcase
    endfunction

    // Illegal one-hot patterns (zero or several bits set) degrade to noop.
    if (ONEHOT_IN != 0) begin : g_onehot
        assign w_opcBad = ($countones(opcode_i) != 1);
        always_comb begin
            w_opcDec = 3'd7;
            for (int i = 0; i < 8; i++) begin
                if (opcode_i[i]) begin
                    w_opcDec = 3'(i);
                end
            end
            if (w_opcBad) begin
                w_opcDec = 3'd7;
            end
        end
    end else begin : g_binary
        assign w_opcDec = opcode_i;
        assign w_opcBad = 1'b0;
    end

    assign w_ready    = (r_upc == '0) && !r_halted;
    assign w_transfer = instr_valid_i && w_ready;

    always_comb begin
        w_nxt     = romNext(r_upc);
        w_upcNext = r_upc;
        w_doneEvt = 1'b0;
        case (w_nxt)
            NX_SEQ:  w_upcNext = r_upc + UPC_W'(1);
            NX_WAIT: begin
                if (w_transfer) begin
                    w_upcNext = UPC_W'(1);
                end
            end
            NX_DISPATCH: begin
                case (r_opcode)
                    3'd0:    w_upcNext = UPC_W'(2);
                    3'd1:    w_upcNext = UPC_W'(4);
                    3'd2:    w_upcNext = UPC_W'(6);
                    3'd3:    w_upcNext = UPC_W'(9);
                    3'd4:    w_upcNext = UPC_W'(11);
                    3'd5:    w_upcNext = UPC_W'(13);
                    3'd6:    w_upcNext = UPC_W'(15);
                    default: w_upcNext = UPC_W'(16);
                endcase
            end
            NX_DONE: begin
                w_upcNext = '0;
                w_doneEvt = 1'b1;
            end
            NX_BEQ: begin
                if (eq_i) begin
                    w_upcNext = UPC_W'(12);
                end else begin
                    w_upcNext = '0;
                    w_doneEvt = 1'b1;
                end
            end
            default: w_upcNext = r_upc;
        endcase
    end

    // ctrl_o is looked up from the next micro-PC so it always matches ROM[upc].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upc     <= '0;
            r_ctrl    <= 8'hC0;
            r_done    <= 1'b0;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
            r_opcode  <= 3'd7;
        end else begin
            r_upc     <= w_upcNext;
            r_ctrl    <= romCtrl(w_upcNext);
            r_done    <= w_doneEvt;
            r_halted  <= r_halted || (w_nxt == NX_HALT);
            r_illegal <= w_transfer && w_opcBad;
            if (w_transfer) begin
                r_opcode <= w_opcDec;
            end
        end
    end

    assign instr_ready_o = w_ready;
    assign ctrl_o        = r_ctrl;
    assign instr_done_o  = r_done;
    assign busy_o        = (r_upc != '0);
    assign halted_o      = r_halted;
    assign illegal_o     = r_illegal;
    assign upc_o         = r_upc;

endmodule

// File: tb/tb_ucode_sequencer.sv
// Directed bench for ucode_sequencer: binary and one-hot instances, with a
// queue of expected done-cycles checked whenever a done pulse appears.
module tb_ucode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       bValid, bEq;
    logic [2:0] bOpc;
    logic       bReady, bDone, bBusy, bHalted, bIllegal;
    logic [7:0] bCtrl;
    logic [4:0] bUpc;

    logic       oValid, oEq;
    logic [7:0] oOpc;
    logic       oReady, oDone, oBusy, oHalted, oIllegal;
    logic [7:0] oCtrl;
    logic [4:0] oUpc;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int qB[$];
    int qO[$];

    always #5 clk = ~clk;

    ucode_sequencer #(.UPC_W(5), .ONEHOT_IN(0)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(bValid), .opcode_i(bOpc), .eq_i(bEq),
        .instr_ready_o(bReady), .ctrl_o(bCtrl), .instr_done_o(bDone), .busy_o(bBusy),
        .halted_o(bHalted), .illegal_o(bIllegal), .upc_o(bUpc)
    );

    ucode_sequencer #(.UPC_W(5), .ONEHOT_IN(1)) dutOh (
        .clk(clk), .rst_n(rst_n), .instr_valid_i(oValid), .opcode_i(oOpc), .eq_i(oEq),
        .instr_ready_o(oReady), .ctrl_o(oCtrl), .instr_done_o(oDone), .busy_o(oBusy),
        .halted_o(oHalted), .illegal_o(oIllegal), .upc_o(oUpc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; any done pulse must match the head of its scoreboard queue.
    task automatic tick();
        @(posedge clk);
        cyc++;
        #1;
        if (bDone) begin
            if (qB.size() > 0) checkOutput("bin_done_cycle", cyc, qB.pop_front());
            else checkOutput("bin_spurious_done", bDone, 0);
        end
        if (oDone) begin
            if (qO.size() > 0) checkOutput("oh_done_cycle", cyc, qO.pop_front());
            else checkOutput("oh_spurious_done", oDone, 0);
        end
    endtask

    task automatic checkAt(input string tag, input int u, input logic [7:0] c);
        checkOutput({tag, "_upc"}, bUpc, u);
        checkOutput({tag, "_ctrl"}, bCtrl, c);
    endtask

    task automatic tickCheck(input string tag, input int u, input logic [7:0] c);
        tick();
        checkAt(tag, u, c);
    endtask

    task automatic checkAtOh(input string tag, input int u, input logic [7:0] c);
        checkOutput({tag, "_upc"}, oUpc, u);
        checkOutput({tag, "_ctrl"}, oCtrl, c);
    endtask

    task automatic applyStimulus(input logic [2:0] op, input logic eq, input int lat);
        checkOutput("bin_ready_at_issue", bReady, 1);
        bValid = 1'b1;
        bOpc   = op;
        bEq    = eq;
        if (lat > 0) qB.push_back(cyc + lat);
        tick();
        bValid = 1'b0;
        bOpc   = 3'($urandom);
    endtask

    task automatic applyStimulusOh(input logic [7:0] op, input int lat);
        checkOutput("oh_ready_at_issue", oReady, 1);
        oValid = 1'b1;
        oOpc   = op;
        qO.push_back(cyc + lat);
        tick();
        oValid = 1'b0;
        oOpc   = 8'($urandom);
    endtask

    initial begin
        rst_n = 1'b0;
        bValid = 1'b0; bOpc = 3'd0; bEq = 1'b0;
        oValid = 1'b0; oOpc = 8'd0; oEq = 1'b0;

        tick();
        checkAt("reset", 0, 8'hC0);
        checkOutput("reset_done", bDone, 0);
        checkOutput("reset_halted", bHalted, 0);
        checkOutput("reset_illegal", bIllegal, 0);
        #6 rst_n = 1'b1;

        for (int i = 0; i < 5; i++) begin
            tickCheck("idle", 0, 8'hC0);
            checkOutput("idle_ready", bReady, 1);
            checkOutput("idle_busy", bBusy, 0);
        end

        // add: upc 1,2,3,0 with done on the return to 0
        applyStimulus(3'd0, 1'b0, 4);
        checkAt("add1", 1, 8'h00);
        checkOutput("add_busy", bBusy, 1);
        tickCheck("add2", 2, 8'h00);
        tickCheck("add3", 3, 8'h10);
        tickCheck("add4", 0, 8'hC0);

        // lw immediately followed by sw with valid held high throughout
        checkOutput("lw_ready", bReady, 1);
        bValid = 1'b1;
        bOpc   = 3'd2;
        qB.push_back(cyc + 5);
        qB.push_back(cyc + 9);
        tick();
        checkAt("lw1", 1, 8'h00);
        bOpc = 3'd3;
        tickCheck("lw2", 6, 8'h00);
        checkOutput("lw_not_ready", bReady, 0);
        tickCheck("lw3", 7, 8'h08);
        tickCheck("lw4", 8, 8'h18);
        tickCheck("lw5", 0, 8'hC0);
        checkOutput("sw_ready", bReady, 1);
        tick();
        bValid = 1'b0;
        checkAt("sw1", 1, 8'h00);
        tickCheck("sw2", 9, 8'h00);
        tickCheck("sw3", 10, 8'h04);
        tickCheck("sw4", 0, 8'hC0);

        // beq taken, then not taken
        applyStimulus(3'd4, 1'b1, 4);
        checkAt("beqT1", 1, 8'h00);
        tickCheck("beqT2", 11, 8'h02);
        tickCheck("beqT3", 12, 8'h40);
        tickCheck("beqT4", 0, 8'hC0);
        applyStimulus(3'd4, 1'b0, 3);
        checkAt("beqN1", 1, 8'h00);
        tickCheck("beqN2", 11, 8'h02);
        tickCheck("beqN3", 0, 8'hC0);

        // nand, jalr, noop
        applyStimulus(3'd1, 1'b0, 4);
        checkAt("nand1", 1, 8'h00);
        tickCheck("nand2", 4, 8'h01);
        tickCheck("nand3", 5, 8'h11);
        tickCheck("nand4", 0, 8'hC0);
        applyStimulus(3'd5, 1'b0, 4);
        checkAt("jalr1", 1, 8'h00);
        tickCheck("jalr2", 13, 8'h12);
        tickCheck("jalr3", 14, 8'h60);
        tickCheck("jalr4", 0, 8'hC0);
        applyStimulus(3'd7, 1'b0, 3);
        checkAt("noop1", 1, 8'h00);
        tickCheck("noop2", 16, 8'h00);
        tickCheck("noop3", 0, 8'hC0);
        checkOutput("bin_illegal_tied", bIllegal, 0);

        // one-hot instance: lw, then a malformed opcode that runs as noop
        applyStimulusOh(8'b0000_0100, 5);
        checkAtOh("ohlw1", 1, 8'h00);
        tick(); checkAtOh("ohlw2", 6, 8'h00);
        tick(); checkAtOh("ohlw3", 7, 8'h08);
        tick(); checkAtOh("ohlw4", 8, 8'h18);
        tick(); checkAtOh("ohlw5", 0, 8'hC0);
        checkOutput("ohlw_illegal", oIllegal, 0);
        applyStimulusOh(8'b0000_0110, 3);
        checkOutput("ohbad_illegal_t1", oIllegal, 1);
        checkAtOh("ohbad1", 1, 8'h00);
        tick();
        checkOutput("ohbad_illegal_t2", oIllegal, 0);
        checkAtOh("ohbad2", 16, 8'h00);
        tick();
        checkAtOh("ohbad3", 0, 8'hC0);

        // halt is sticky until reset
        applyStimulus(3'd6, 1'b0, 0);
        checkAt("halt1", 1, 8'h00);
        tickCheck("halt2", 15, 8'h00);
        checkOutput("halt_t2_halted", bHalted, 0);
        tickCheck("halt3", 15, 8'h00);
        checkOutput("halt_t3_halted", bHalted, 1);
        bValid = 1'b1;
        bOpc   = 3'd0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("halt_ready", bReady, 0);
            checkOutput("halt_busy", bBusy, 1);
            checkOutput("halt_upc", bUpc, 15);
        end
        #3 rst_n = 1'b0;
        bValid = 1'b0;
        #1;
        checkAt("halt_rst", 0, 8'hC0);
        checkOutput("halt_rst_halted", bHalted, 0);
        checkOutput("halt_rst_ready", bReady, 1);
        checkOutput("halt_rst_busy", bBusy, 0);
        #1 rst_n = 1'b1;

        // reset mid-lw at upc 7 aborts without a done pulse
        tick();
        applyStimulus(3'd2, 1'b0, 0);
        checkAt("abort1", 1, 8'h00);
        tickCheck("abort2", 6, 8'h00);
        tickCheck("abort3", 7, 8'h08);
        #3 rst_n = 1'b0;
        #1;
        checkAt("abort_rst", 0, 8'hC0);
        checkOutput("abort_rst_done", bDone, 0);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("abort_no_done", bDone, 0);
        end

        checkOutput("bin_pending", qB.size(), 0);
        checkOutput("oh_pending", qO.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ucode_sequencer.md
Name: ucode_sequencer

Overview:
- Parametrised microcoded control unit for the multicycle LC-2K-style core; successor to the single-word opcode-to-control lookup.
- Accepts one instruction per handshake, walks a per-opcode microprogram one state per clock, and emits an 8-bit control word every cycle.
- Adds over the old lookup: a micro-PC, multi-cycle sequencing, a conditional branch micro-op, halt latching, instruction-done signalling, and binary or one-hot opcode input.

Parameters:
- UPC_W, 5, micro-PC width; ROM depth is 2**UPC_W; must be >=5.
- ONEHOT_IN, 0, 0 = binary 3-bit opcode; 1 = legacy 8-bit one-hot opcode.
- OPC_IN_W, (ONEHOT_IN ? 8 : 3), derived opcode input width; not overridden.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- instr_valid_i  input  1  opcode_i valid
- opcode_i  input  OPC_IN_W  binary: add0 nand1 lw2 sw3 beq4 jalr5 halt6 noop7; one-hot: bit n = opcode n
- eq_i  input  1  register-compare result, sampled in BEQ_CMP
- instr_ready_o  output  1  sequencer accepts an opcode this cycle
- ctrl_o  output  8  [7]ir_we [6]pc_we [5]pc_sel [4]reg_we [3]mem_re [2]mem_we [1:0]alu_op (0 add, 1 nand, 2 pass)
- instr_done_o  output  1  one-cycle pulse on instruction completion
- busy_o  output  1  upc != 0
- halted_o  output  1  sticky halt flag
- illegal_o  output  1  one-cycle pulse on a malformed one-hot opcode
- upc_o  output  UPC_W  current micro-PC (debug)

Behaviour:
- Reset (async, rst_n low): upc=0, halted_o=0, instr_done_o=0, illegal_o=0, latched opcode=noop, ctrl_o=0xC0 (ROM[0]). Asserting reset mid-instruction aborts it; no done pulse is produced.
- ctrl_o always equals ROM[upc]. It is a registered output, loaded from ROM[upc_next].
- ROM contents (addr: ctrl, next):
  - 0 FETCH: 0xC0, WAIT
  - 1 DECODE: 0x00, DISPATCH
  - 2 ADD_EX: 0x00, SEQ
  - 3 ADD_WB: 0x10, DONE
  - 4 NAND_EX: 0x01, SEQ
  - 5 NAND_WB: 0x11, DONE
  - 6 LW_ADDR: 0x00, SEQ
  - 7 LW_MEM: 0x08, SEQ
  - 8 LW_WB: 0x18, DONE
  - 9 SW_ADDR: 0x00, SEQ
  - 10 SW_MEM: 0x04, DONE
  - 11 BEQ_CMP: 0x02, BEQ
  - 12 BEQ_PC: 0x40, DONE
  - 13 JALR_LINK: 0x12, SEQ
  - 14 JALR_PC: 0x60, DONE
  - 15 HALT: 0x00, HALT
  - 16 NOOP: 0x00, DONE
  - 17 through 2**UPC_W-1: 0x00, DONE (unreachable)
- Next-field actions:
  - SEQ: upc+1.
  - WAIT: hold at upc until the handshake, then go to 1.
  - DISPATCH: add->2, nand->4, lw->6, sw->9, beq->11, jalr->13, halt->15, noop->16.
  - DONE: go to 0.
  - BEQ: eq_i=1 ->12, else go to 0 (DONE).
  - HALT: hold at upc.
- Handshake:
  - instr_ready_o = (upc==0) & ~halted_o.
  - Transfer happens when instr_valid_i & instr_ready_o; opcode is latched on that edge.
  - opcode_i is ignored when no transfer occurs.
- instr_done_o is registered. It is high for exactly the one cycle in which upc has just returned to 0 via DONE, so back-to-back issue is possible in that same cycle.
- Latency, with the transfer edge at cycle t:
  - add, nand, sw, beq taken, jalr, noop(3 cycles: t+3): done pulse at t+4, except noop at t+3.
  - lw: done at t+5.
  - beq not taken: done at t+3.
- halt: upc=15 at t+2, halted_o=1 from t+3. After that instr_ready_o=0, busy_o=1, and no done pulse occurs. Only reset clears it.
- ONEHOT_IN=1 with popcount(opcode_i)!=1 at transfer: illegal_o pulses in the cycle after transfer, and the instruction executes as noop.
- ONEHOT_IN=0: illegal_o is tied 0.
- upc_next arithmetic is modulo 2**UPC_W. SEQ never targets beyond 16 with the fixed table.

Test Plan:
- Reset, then hold instr_valid_i=0 for 5 cycles -> upc_o=0, ctrl_o=0xC0, instr_ready_o=1, busy_o=0, no done.
- Issue add at t -> upc 1,2,3,0 at t+1..t+4; ctrl 0x00,0x00,0x10,0xC0; instr_done_o=1 only at t+4.
- lw immediately followed by sw (valid held high) -> lw done at t+5 with ctrl 0x08 then 0x18 seen; sw accepted at t+5 and done at t+9, with ctrl 0x04 at upc 10.
- beq with eq_i=1 -> ctrl 0x40 seen, done at t+4. beq with eq_i=0 -> upc 11->0, done at t+3, no 0x40.
- halt -> halted_o=1 at t+3. A later valid add is never accepted and instr_ready_o stays 0. Pulse rst_n low asynchronously mid-cycle -> all outputs immediately at reset values.
- ONEHOT_IN=1: opcode 8'b00000100 -> lw sequence, done t+5. Opcode 8'b00000110 -> illegal_o pulse at t+1, done at t+3.
- Reset asserted at upc=7 during lw -> upc_o=0 at once, and no instr_done_o pulse afterwards.
